tube_display_ctrl: RTL and testbench
====================================

# tube_display_ctrl

Memory-mapped 8-digit seven-segment display controller inside `cpu_top`, downstream of the CPU's MMIO write path. It drives `tube_scan`, `tube_signal_left` and `tube_signal_right` on the board. It holds a 32-bit display value and shows it in hex or unsigned decimal. Decimal digits come from a sequential 32-iteration double-dabble converter. A divided time-multiplexed scan with per-digit enable and decimal-point masks drives the digits.

## Interface
- `SCAN_DIV`, default 100000: clocks per digit slot; legal values ≥2. Benches use 4.
- `clk_100`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  register write strobe, one cycle per write.
- `addr`  in  2  register select: 0 VALUE, 1 MODE, 2 DIGIT_EN, 3 DP.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  combinational readback of the register selected by `addr`.
- `tube_scan`  out  8  one-hot digit enable, active-high; bit i = digit i, digit 0 rightmost.
- `tube_signal_left`  out  8  segments for digits 7..4, {dp,g,f,e,d,c,b,a}, active-high.
- `tube_signal_right`  out  8  segments for digits 3..0, same encoding.

## Operation
- Registers and reset values:
  - VALUE[31:0] = 0.
  - MODE[1:0] = 0: bit0 selects decimal, bit1 enables leading-zero blanking (decimal only).
  - DIGIT_EN[7:0] = 8'hFF.
  - DP[7:0] = 0.
- Unused write bits are ignored.
- Readback:
  - Unused bits read 0.
  - MODE readback bit31 is `busy`.
- Hex mode: digit i shows VALUE[4i+3:4i]. Font:
  - 0–7: 3F 06 5B 4F 66 6D 7D 07.
  - 8–F: 7F 6F 77 7C 39 5E 79 71.
- Decimal mode, conversion:
  - Any write to VALUE or MODE while MODE.bit0=1 (after the write) starts a conversion: `busy`=1 for exactly 32 cycles.
  - Conversion is a shift-add-3 double-dabble into a 32-bit BCD register.
  - On completion the BCD register is copied to the display BCD latch and `busy` drops.
  - A qualifying write while busy restarts the conversion from the new value (latest wins).
  - The display keeps the previous latch contents until completion.
- Decimal mode, display:
  - If VALUE > 99999999, the latch is loaded with the overflow pattern: every digit shows '-' (8'h40).
  - With blanking enabled, leading zero digits above the most significant nonzero digit are blank (segments 0).
  - Digit 0 is never blanked.
- Hex mode uses VALUE directly; no conversion, `busy` stays 0.
- Switching MODE.bit0 to 0 mid-conversion aborts it: `busy` drops and the latch is unchanged.
- Scan:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, `idx` increments modulo 8 (7→0).
- Outputs:
  - Outputs are registered from `idx` and the current display data.
  - `tube_scan` = 1<<idx if DIGIT_EN[idx], else 0.
  - The active bus (left for idx≥4, right otherwise) carries font | (DP[idx]<<7).
  - The inactive bus and any disabled digit's bus are 8'h00.
- A disabled digit still consumes its slot, so the scan period is fixed at 8·SCAN_DIV cycles.

## Timing
- Reset, async on `rst_n` low:
  - Registers go to the values above.
  - `div_cnt`=0, `idx`=0, `busy`=0, BCD latch=0.
  - `tube_scan`=8'h01, `tube_signal_right`=8'h3F, `tube_signal_left`=8'h00.
- Reset deasserted mid-conversion restarts cleanly with no conversion pending.
- Write latency:
  - A register write at edge t is visible on `rd_data` after t.
  - In hex mode it affects the segment outputs at edge t+1, for the digit currently scanned.
- Decimal latency: write at edge t; `busy` is high for edges t+1..t+32 and low after t+32; the latch updates at t+32; segments reflect it at t+33.
- Scan timing:
  - `idx` advances on the edge where `div_cnt`=SCAN_DIV-1.
  - Outputs follow one edge later.
  - Each digit is active for exactly SCAN_DIV cycles.
- A write and a scan advance on the same edge are both honored.

## Test plan
- Reset, then hex VALUE=32'h1234ABCD, SCAN_DIV=4 → digits 0..7 show 5E 39 7C 77 66 4F 5B 06; `tube_scan` walks 01,02,…,80 every 4 cycles; left bus is 0 during digits 0–3.
- MODE=1 (decimal, no blanking), VALUE=12345678 → `busy` high 32 cycles; then digits 0..7 show 8,7,6,5,4,3,2,1 (7F 07 7D 6D 66 4F 5B 06).
- MODE=3, VALUE=0 → digit 0 shows 3F; digits 1–7 segments 00 with `tube_scan` still one-hot. Then VALUE=100000000 → all digits 8'h40.
- Decimal VALUE=5, then VALUE=99999999 written 10 cycles later → display changes only once, to all 6F, 32 cycles after the second write.
- DIGIT_EN=8'h0F, DP=8'h02 → `tube_scan`=0 in slots 4–7; digit 1 segments carry bit7=1.
- Assert `rst_n` low mid-scan and mid-conversion → outputs immediately 8'h01/8'h3F/8'h00 and `busy`=0; readback VALUE=0, DIGIT_EN=FF.

Source files
------------

// File: rtl/tube_display_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: hex or decimal display
// (sequential double-dabble), with time-multiplexed scan plus enable and DP masks.
module tube_display_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk_100,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [7:0]  tube_scan,
    output logic [7:0]  tube_signal_left,
    output logic [7:0]  tube_signal_right
);
    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CONV_W = 5;
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(31);
    localparam logic [31:0] DEC_MAX  = 32'd99999999;
    localparam logic [7:0]  SEG_DASH = 8'h40;
    localparam logic [1:0]  A_VALUE  = 2'd0;
    localparam logic [1:0]  A_MODE   = 2'd1;
    localparam logic [1:0]  A_DEN    = 2'd2;
    localparam logic [1:0]  A_DP     = 2'd3;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             state_q, state_d;
    logic [31:0]        value_q, value_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         den_q, den_d;
    logic [7:0]         dp_q, dp_d;
    logic [CONV_W-1:0]  cnt_q, cnt_d;
    logic [31:0]        bin_q, bin_d;
    logic [31:0]        bcd_q, bcd_d;
    logic [31:0]        latch_q, latch_d;
    logic               conv_ovf_q, conv_ovf_d;
    logic               latch_ovf_q, latch_ovf_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         scan_q, scan_d;
    logic [7:0]         left_q, left_d;
    logic [7:0]         right_q, right_d;

    logic [63:0]        dd_next_c;
    logic [3:0]         nib_c;
    logic [7:0]         seg_c;
    logic               start_c;
    logic [31:0]        src_c;

    function automatic logic [7:0] font(input logic [3:0] n);
        case (n)
            4'h0:    font = 8'h3F;
            4'h1:    font = 8'h06;
            4'h2:    font = 8'h5B;
            4'h3:    font = 8'h4F;
            4'h4:    font = 8'h66;
            4'h5:    font = 8'h6D;
            4'h6:    font = 8'h7D;
            4'h7:    font = 8'h07;
            4'h8:    font = 8'h7F;
            4'h9:    font = 8'h6F;
            4'hA:    font = 8'h77;
            4'hB:    font = 8'h7C;
            4'hC:    font = 8'h39;
            4'hD:    font = 8'h5E;
            4'hE:    font = 8'h79;
            default: font = 8'h71;
        endcase
    endfunction

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left.
    function automatic logic [63:0] dd_step(input logic [31:0] bcd, input logic [31:0] bin);
        logic [31:0] adj;
        adj = bcd;
        for (int d = 0; d < 8; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        return {adj[30:0], bin[31], bin[30:0], 1'b0};
    endfunction

    assign dd_next_c = dd_step(bcd_q, bin_q);

    // Segment pattern of the digit under the scan pointer.
    always_comb begin
        nib_c = mode_q[0] ? latch_q[{idx_q, 2'b00} +: 4] : value_q[{idx_q, 2'b00} +: 4];
        seg_c = font(nib_c);
        if (mode_q[0]) begin
            if (latch_ovf_q) begin
                seg_c = SEG_DASH;
            end else if (mode_q[1] && (idx_q != 3'd0) && ((latch_q >> {idx_q, 2'b00}) == 32'd0)) begin
                seg_c = 8'h00;
            end
        end
        seg_c = seg_c | {dp_q[idx_q], 7'b0};
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            A_VALUE: rd_data = value_q;
            A_MODE:  rd_data = {(state_q == S_CONV), 29'd0, mode_q};
            A_DEN:   rd_data = {24'd0, den_q};
            default: rd_data = {24'd0, dp_q};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        mode_d      = mode_q;
        den_d       = den_q;
        dp_d        = dp_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        latch_d     = latch_q;
        conv_ovf_d  = conv_ovf_q;
        latch_ovf_d = latch_ovf_q;
        div_cnt_d   = div_cnt_q;
        idx_d       = idx_q;
        start_c     = 1'b0;
        src_c       = value_q;

        if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        scan_d  = den_q[idx_q] ? (8'h01 << idx_q) : 8'h00;
        left_d  = (den_q[idx_q] && idx_q[2])  ? seg_c : 8'h00;
        right_d = (den_q[idx_q] && !idx_q[2]) ? seg_c : 8'h00;

        if (state_q == S_CONV) begin
            bcd_d = dd_next_c[63:32];
            bin_d = dd_next_c[31:0];
            cnt_d = cnt_q + CONV_W'(1);
            if (cnt_q == CONV_LAST) begin
                state_d     = S_IDLE;
                latch_d     = dd_next_c[63:32];
                latch_ovf_d = conv_ovf_q;
            end
        end

        if (wr_en) begin
            case (addr)
                A_VALUE: begin
                    value_d = wr_data;
                    if (mode_q[0]) begin
                        start_c = 1'b1;
                        src_c   = wr_data;
                    end
                end
                A_MODE: begin
                    mode_d = wr_data[1:0];
                    if (wr_data[0]) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                A_DEN:   den_d = wr_data[7:0];
                default: dp_d  = wr_data[7:0];
            endcase
        end

        // Latest qualifying write restarts the conversion from scratch.
        if (start_c) begin
            state_d    = S_CONV;
            cnt_d      = '0;
            bin_d      = src_c;
            bcd_d      = 32'd0;
            conv_ovf_d = (src_c > DEC_MAX);
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            value_q     <= 32'd0;
            mode_q      <= 2'd0;
            den_q       <= 8'hFF;
            dp_q        <= 8'h00;
            cnt_q       <= '0;
            bin_q       <= 32'd0;
            bcd_q       <= 32'd0;
            latch_q     <= 32'd0;
            conv_ovf_q  <= 1'b0;
            latch_ovf_q <= 1'b0;
            div_cnt_q   <= '0;
            idx_q       <= 3'd0;
            scan_q      <= 8'h01;
            left_q      <= 8'h00;
            right_q     <= 8'h3F;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            mode_q      <= mode_d;
            den_q       <= den_d;
            dp_q        <= dp_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            latch_q     <= latch_d;
            conv_ovf_q  <= conv_ovf_d;
            latch_ovf_q <= latch_ovf_d;
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            scan_q      <= scan_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    assign tube_scan         = scan_q;
    assign tube_signal_left  = left_q;
    assign tube_signal_right = right_q;

endmodule

// File: tb/tb_tube_display_ctrl.sv
// Self-checking bench for tube_display_ctrl: register table, directed display
// sequences, and randomized traffic against a cycle-count based reference model.
module tb_tube_display_ctrl;
    localparam int S = 4;
    localparam logic [1:0] A_VAL  = 2'd0;
    localparam logic [1:0] A_MODE = 2'd1;
    localparam logic [1:0] A_DEN  = 2'd2;
    localparam logic [1:0] A_DP   = 2'd3;
    localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    localparam logic [63:0] SCAN_ALL = 64'h80402010_08040201;

    logic        clk_100 = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [1:0]  addr    = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic [7:0]  tube_scan, tube_signal_left, tube_signal_right;

    tube_display_ctrl #(.SCAN_DIV(S)) dut (
        .clk_100          (clk_100),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .addr             (addr),
        .wr_data          (wr_data),
        .rd_data          (rd_data),
        .tube_scan        (tube_scan),
        .tube_signal_left (tube_signal_left),
        .tube_signal_right(tube_signal_right)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  mode;
        logic [7:0]  den;
        logic [7:0]  dp;
        int unsigned lat_val;
        bit          lat_ovf;
        bit          pending;
        logic [31:0] pend_val;
        int          done_at;
    } model_t;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    model_t     m, prev;
    int         k;
    int         n_checks = 0;
    int         n_err    = 0;
    logic [1:0] rd_sel   = 2'd0;
    logic [7:0] cap_scan [8];
    logic [7:0] cap_seg  [8];
    logic [7:0] cap_oth  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    function automatic model_t model_reset();
        model_t r;
        r.value = 32'd0; r.mode = 2'd0; r.den = 8'hFF; r.dp = 8'h00;
        r.lat_val = 0; r.lat_ovf = 1'b0; r.pending = 1'b0; r.pend_val = 32'd0; r.done_at = 0;
        return r;
    endfunction

    function automatic int unsigned p10(input int n);
        int unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Expected registered outputs for a given register state and scanned digit.
    function automatic void exp_out(input model_t s, input int idx,
                                    output logic [7:0] sc, output logic [7:0] l, output logic [7:0] r);
        logic [7:0] seg;
        if (!s.mode[0])                                  seg = FONT[4'((s.value >> (4 * idx)) & 32'hF)];
        else if (s.lat_ovf)                              seg = 8'h40;
        else if (s.mode[1] && idx > 0 && s.lat_val < p10(idx)) seg = 8'h00;
        else                                             seg = FONT[4'((s.lat_val / p10(idx)) % 10)];
        if (s.dp[idx]) seg = seg | 8'h80;
        sc = s.den[idx] ? (8'h01 << idx) : 8'h00;
        l  = (s.den[idx] && idx >= 4) ? seg : 8'h00;
        r  = (s.den[idx] && idx < 4)  ? seg : 8'h00;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            A_VAL:   return m.value;
            A_MODE:  return {m.pending, 29'd0, m.mode};
            A_DEN:   return {24'd0, m.den};
            default: return {24'd0, m.dp};
        endcase
    endfunction

    task automatic model_start(input logic [31:0] v);
        m.pending  = 1'b1;
        m.pend_val = v;
        m.done_at  = k + 32;
    endtask

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
        prev = m;
        if (m.pending && k == m.done_at) begin
            m.lat_ovf = (m.pend_val > 32'd99999999);
            m.lat_val = m.pend_val;
            m.pending = 1'b0;
        end
        if (we) begin
            case (a)
                A_VAL: begin
                    m.value = d;
                    if (m.mode[0]) model_start(d);
                end
                A_MODE: begin
                    m.mode = d[1:0];
                    if (d[0]) model_start(m.value);
                    else      m.pending = 1'b0;
                end
                A_DEN:   m.den = d[7:0];
                default: m.dp  = d[7:0];
            endcase
        end
    endtask

    // One clock: optional write, then compare outputs and readback with the model.
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
        logic [7:0] es, el, er;
        wr_en = we; addr = a; wr_data = d;
        @(posedge clk_100);
        k++;
        model_edge(we, a, d);
        #1;
        wr_en = 1'b0;
        addr  = rd_sel;
        #1;
        exp_out(prev, ((k - 1) / S) % 8, es, el, er);
        chk("scan",  32'(tube_scan),         32'(es));
        chk("left",  32'(tube_signal_left),  32'(el));
        chk("right", 32'(tube_signal_right), 32'(er));
        chk("rd_data", rd_data, model_rd(rd_sel));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_scan",  32'(tube_scan),         32'h01);
        chk("rst_right", 32'(tube_signal_right), 32'h3F);
        chk("rst_left",  32'(tube_signal_left),  32'h00);
        addr = A_MODE; #1 chk("rst_mode_busy", rd_data, 32'h0);
        addr = A_VAL;  #1 chk("rst_value",     rd_data, 32'h0);
        addr = A_DEN;  #1 chk("rst_digit_en",  rd_data, 32'hFF);
        m = model_reset();
        k = 0;
        @(negedge clk_100);
        rst_n = 1'b1;
    endtask

    task automatic capture_frame();
        int guard = 0;
        while (!(((k - 1) % S) == 0 && (((k - 1) / S) % 8) == 0) && guard < 8 * S + 4) begin
            idle(1);
            guard++;
        end
        chk("frame_align", 32'(guard < 8 * S + 4), 32'd1);
        for (int d = 0; d < 8; d++) begin
            cap_scan[d] = tube_scan;
            cap_seg[d]  = (d >= 4) ? tube_signal_left  : tube_signal_right;
            cap_oth[d]  = (d >= 4) ? tube_signal_right : tube_signal_left;
            if (d < 7) idle(S);
        end
    endtask

    task automatic check_frame(input string name, input logic [63:0] segs, input logic [63:0] scans);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            chk({name, "_seg"},   32'(cap_seg[d]),  32'(segs[8 * d +: 8]));
            chk({name, "_scan"},  32'(cap_scan[d]), 32'(scans[8 * d +: 8]));
            chk({name, "_other"}, 32'(cap_oth[d]),  32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   bc;
        bit   early;
        logic [31:0] v;

        vecs = '{'{A_VAL,  32'hDEADBEEF, 32'hDEADBEEF},
                 '{A_MODE, 32'hFFFFFFFC, 32'h00000000},
                 '{A_MODE, 32'h00000002, 32'h00000002},
                 '{A_DEN,  32'h123456A5, 32'h000000A5},
                 '{A_DP,   32'hFFFFFF3C, 32'h0000003C},
                 '{A_DEN,  32'hFFFFFFFF, 32'h000000FF},
                 '{A_DP,   32'h00000000, 32'h00000000},
                 '{A_MODE, 32'h00000000, 32'h00000000},
                 '{A_VAL,  32'h00000000, 32'h00000000}};

        m = model_reset();
        k = 0;
        repeat (2) @(posedge clk_100);
        #2;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            rd_sel = vecs[i].a;
            step(1'b1, vecs[i].a, vecs[i].d);
            chk("reg_table", rd_data, vecs[i].exp_rd);
        end

        // Hex display of 1234ABCD
        step(1'b1, A_VAL, 32'h1234ABCD);
        check_frame("hex", 64'h065B4F66_777C395E, SCAN_ALL);

        // Decimal 12345678: busy for exactly 32 cycles, then digits appear
        rd_sel = A_MODE;
        step(1'b1, A_MODE, 32'd1);
        idle(5);
        step(1'b1, A_VAL, 32'd12345678);
        bc = rd_data[31] ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (rd_data[31]) bc++;
        end
        chk("busy_cycles", 32'(bc), 32'd32);
        check_frame("dec", 64'h065B4F66_6D7D077F, SCAN_ALL);

        // Blanking of zero, then overflow
        step(1'b1, A_MODE, 32'd3);
        step(1'b1, A_VAL, 32'd0);
        idle(40);
        check_frame("blank", 64'h00000000_0000003F, SCAN_ALL);
        step(1'b1, A_VAL, 32'd100000000);
        idle(40);
        check_frame("ovf", 64'h40404040_40404040, SCAN_ALL);

        // Restart while busy: only the latest value ever reaches the display
        early = 1'b0;
        step(1'b1, A_VAL, 32'd5);
        if ((tube_signal_left | tube_signal_right) != 8'h40) early = 1'b1;
        for (int i = 0; i < 9; i++) begin
            idle(1);
            if ((tube_signal_left | tube_signal_right) != 8'h40) early = 1'b1;
        end
        step(1'b1, A_VAL, 32'd99999999);
        for (int i = 0; i < 32; i++) begin
            idle(1);
            if ((tube_signal_left | tube_signal_right) != 8'h40) early = 1'b1;
        end
        chk("restart_no_early_change", 32'(early), 32'd0);
        check_frame("restart", 64'h6F6F6F6F_6F6F6F6F, SCAN_ALL);

        // Abort by switching to hex, then digit-enable and DP masks
        step(1'b1, A_VAL, 32'h1234ABCD);
        chk("busy_before_abort", rd_data, 32'h80000003);
        step(1'b1, A_MODE, 32'd0);
        chk("abort_busy", rd_data, 32'h0);
        step(1'b1, A_DEN, 32'h0F);
        step(1'b1, A_DP, 32'h02);
        check_frame("mask", 64'h00000000_777CB95E, 64'h00000000_08040201);

        // Reset mid-conversion and mid-scan
        step(1'b1, A_DEN, 32'hFF);
        step(1'b1, A_DP, 32'h00);
        step(1'b1, A_MODE, 32'd1);
        step(1'b1, A_VAL, 32'd12345678);
        idle(10);
        do_reset();
        rd_sel = A_MODE;
        idle(40);
        chk("post_reset_idle", rd_data, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rd_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                logic [1:0] a;
                a = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0:       v = $urandom;
                    1:       v = 32'($urandom_range(0, 99999999));
                    2:       v = 32'($urandom_range(0, 999));
                    3:       v = 32'd99999999;
                    default: v = 32'd100000000;
                endcase
                if (a == A_MODE) v = {v[31:2], 2'($urandom_range(0, 3))};
                step(1'b1, a, v);
            end else begin
                idle(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
